// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: sequencing opcodes, microinstruction
// field positions, error codes and the controller state type.
package microseq_pkg;

    localparam int DEFAULT_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        SEQ_NEXT  = 3'b000,
        SEQ_JMP   = 3'b001,
        SEQ_BCOND = 3'b010,
        SEQ_CALL  = 3'b011,
        SEQ_RET   = 3'b100,
        SEQ_END   = 3'b101
    } seq_op_e;

    localparam int SEQ_OP_MSB   = 31;
    localparam int SEQ_OP_LSB   = 29;
    localparam int COND_SEL_MSB = 28;
    localparam int COND_SEL_LSB = 27;
    localparam int COND_INV_BIT = 26;
    localparam int TARGET_MSB   = 25;
    localparam int TARGET_LSB   = 18;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO for CALL/RET. The top entry is visible combinationally so
// a RET can redirect the microcode address in the same cycle it pops.
module microseq_stack #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_clear,
    input  logic [7:0] i_data,
    output logic [7:0] o_top,
    output logic       o_full,
    output logic       o_empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0] r_count;
    logic [7:0]    r_mem [DEPTH];
    logic [CW-1:0] w_top_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_top_idx = r_count - CW'(1);
    assign o_top     = r_mem[w_top_idx[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Entries need no reset: only slots below r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_count[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Microcode sequencer: dispatches a macro-opcode to a microprogram and walks the
// ROM address with NEXT/JMP/BCOND/CALL/RET/END, reporting completion and errors.
module microsequencer
    import microseq_pkg::*;
#(
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  opcode,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] uinstr,
    input  logic [3:0]  cond_flags,
    input  logic        stall,
    output logic [7:0]  uaddr,
    output logic        uvalid,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);
    state_e      r_state;
    logic [7:0]  r_uaddr;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;

    state_e      w_state_next;
    logic [7:0]  w_uaddr_next;
    logic        w_done_next;
    logic        w_err_next;
    logic [1:0]  w_err_code_next;
    logic        w_push;
    logic        w_pop;
    logic        w_clear;

    logic [2:0]  w_seq_op;
    logic [1:0]  w_cond_sel;
    logic        w_cond_inv;
    logic [7:0]  w_target;
    logic        w_taken;
    logic [7:0]  w_uaddr_inc;
    logic [7:0]  w_stack_top;
    logic        w_stack_full;
    logic        w_stack_empty;

    assign w_seq_op    = uinstr[SEQ_OP_MSB:SEQ_OP_LSB];
    assign w_cond_sel  = uinstr[COND_SEL_MSB:COND_SEL_LSB];
    assign w_cond_inv  = uinstr[COND_INV_BIT];
    assign w_target    = uinstr[TARGET_MSB:TARGET_LSB];
    assign w_taken     = cond_flags[w_cond_sel] ^ w_cond_inv;
    assign w_uaddr_inc = r_uaddr + 8'd1;

    microseq_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (w_uaddr_inc),
        .o_top   (w_stack_top),
        .o_full  (w_stack_full),
        .o_empty (w_stack_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_uaddr    <= 8'h00;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_next;
            r_uaddr    <= w_uaddr_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_err_code <= w_err_code_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_uaddr_next    = r_uaddr;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;
        w_err_code_next = r_err_code;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_clear         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    if (opcode[7:6] == 2'b00) begin
                        w_state_next = ST_RUN;
                        w_uaddr_next = {opcode[5:0], 2'b00};
                    end else begin
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_ILLEGAL;
                    end
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    case (w_seq_op)
                        SEQ_JMP:   w_uaddr_next = w_target;
                        SEQ_BCOND: w_uaddr_next = w_taken ? w_target : w_uaddr_inc;
                        SEQ_CALL: begin
                            if (w_stack_full) begin
                                w_state_next    = ST_IDLE;
                                w_clear         = 1'b1;
                                w_err_next      = 1'b1;
                                w_err_code_next = ERR_OVERFLOW;
                            end else begin
                                w_push       = 1'b1;
                                w_uaddr_next = w_target;
                            end
                        end
                        SEQ_RET: begin
                            if (w_stack_empty) begin
                                w_state_next    = ST_IDLE;
                                w_clear         = 1'b1;
                                w_err_next      = 1'b1;
                                w_err_code_next = ERR_UNDERFLOW;
                            end else begin
                                w_pop        = 1'b1;
                                w_uaddr_next = w_stack_top;
                            end
                        end
                        SEQ_END: begin
                            w_state_next = ST_IDLE;
                            w_clear      = 1'b1;
                            w_done_next  = 1'b1;
                        end
                        // Unused encodings fall through as NEXT.
                        default:   w_uaddr_next = w_uaddr_inc;
                    endcase
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign op_ready = (r_state == ST_IDLE);
    assign uvalid   = (r_state == ST_RUN);
    assign uaddr    = r_uaddr;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4: return-stack entries; legal values 2..8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 opcode  input  8  macro-opcode to dispatch.
REQ-005 op_valid  input  1  opcode valid.
REQ-006 op_ready  output  1  sequencer accepts an opcode this cycle.
REQ-007 uinstr  input  32  microinstruction from the microcode ROM at uaddr; combinational, same cycle.
REQ-008 cond_flags  input  4  datapath condition flags.
REQ-009 stall  input  1  datapath hold request.
REQ-010 uaddr  output  8  registered microcode address to the ROM.
REQ-011 uvalid  output  1  uinstr at uaddr is to be executed by the datapath this cycle.
REQ-012 done  output  1  one-cycle pulse: microprogram finished.
REQ-013 err  output  1  one-cycle pulse: sequencing error.
REQ-014 err_code  output  2  01 illegal opcode, 10 stack overflow, 11 stack underflow; held until the next err.

Function
REQ-015 Sequencing fields: uinstr[31:29] seq_op, [28:27] cond_sel, [26] cond_inv, [25:18] target; uinstr[17:0] is ignored.
REQ-016 seq_op: 000 NEXT, 001 JMP, 010 BCOND, 011 CALL, 100 RET, 101 END; 110 and 111 execute as NEXT.
REQ-017 States: IDLE, RUN; op_ready = (state==IDLE); uvalid = (state==RUN).
REQ-018 IDLE with op_valid=1 and opcode[7:6]==00: accept; next cycle RUN, uaddr={opcode[5:0],2'b00}.
REQ-019 IDLE with op_valid=1 and opcode[7:6]!=00: consume the opcode, stay IDLE, err=1 next cycle, err_code=01.
REQ-020 stall is ignored in IDLE.
REQ-021 RUN with stall=1: uaddr, state and stack hold; no outputs pulse.
REQ-022 RUN, NEXT: uaddr <= uaddr+1, modulo 256 (8'hFF wraps to 8'h00).
REQ-023 RUN, JMP: uaddr <= target.
REQ-024 RUN, BCOND: uaddr <= target if cond_flags[cond_sel]^cond_inv; otherwise uaddr+1.
REQ-025 RUN, CALL: push uaddr+1 (wrapped), uaddr <= target.
REQ-026 CALL on a full stack: no push, state <= IDLE, err=1 next cycle, err_code=10.
REQ-027 RUN, RET: uaddr <= popped value.
REQ-028 RET on an empty stack: state <= IDLE, err=1 next cycle, err_code=11.
REQ-029 RUN, END: state <= IDLE, uaddr holds, stack cleared, done=1 for exactly the first IDLE cycle.
REQ-030 Error exits clear the stack and do not assert done.
REQ-031 uaddr holds its value throughout IDLE.
REQ-032 Latency: 1 cycle from accepted handshake to the first uvalid.
REQ-033 Minimum turnaround: a new opcode is accepted in the same cycle done is high.

Reset
REQ-034 On rst: state=IDLE, uaddr=8'h00, stack empty, done=0, err=0, err_code=00; op_ready=1 once rst is released.
REQ-035 rst asserted mid-microprogram aborts immediately, with no done or err pulse.

Structure
REQ-036 Shared package microseq_pkg: seq_op encodings, field bit positions, err_code values, state enum, default STACK_DEPTH.
REQ-037 Return stack is a sub-module microseq_stack: LIFO of 8-bit entries, push/pop/clear ports, full/empty flags.
REQ-038 One same-cycle push or pop only; push and pop never occur together.

Verification
REQ-039 ADD dispatch: opcode 8'h00 with ROM entries 0x00-0x02 NEXT and 0x03 END -> uaddr 00,01,02,03 with uvalid=1, done pulse in the 5th cycle after accept.
REQ-040 Illegal opcode: opcode 8'hC1 -> no RUN, err=1 for one cycle, err_code=01, op_ready stays 1.
REQ-041 Branching: BCOND cond_sel=2, cond_inv=0, target 8'h40, cond_flags=4'b0100 -> uaddr 8'h40; repeat with cond_flags=0 -> uaddr+1.
REQ-042 Call/return: CALL target 8'h80 at 8'h10, RET at 8'h80 -> 10,80,11.
REQ-043 Overflow: five nested CALLs (STACK_DEPTH=4) -> err_code=10 on the 5th and return to IDLE.
REQ-044 Stall and reset: stall high 3 cycles -> uaddr frozen; rst pulse mid-run -> uaddr=00, IDLE, no done/err.
